// File: rtl/mul_err_accum.sv
// Error-statistics accumulator placed after the 8x8 approximate multiplier.
// Pipelines each (a, b, approx) sample and accumulates error count, ED sum and max ED.
module mul_err_accum #(
    parameter int N_W   = 17,
    parameter int ACC_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [N_W-1:0]   num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [15:0]      in_approx,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   sample_count,
    output logic [N_W-1:0]   err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [15:0]      max_ed,
    output logic [7:0]       max_a,
    output logic [7:0]       max_b
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [N_W-1:0] target;
    logic           accept, start_ok, last_accept;

    logic           s1_v;
    logic [7:0]     s1_a, s1_b;
    logic [15:0]    s1_approx;
    logic [15:0]    s1_exact, s1_ed;

    logic           s2_v;
    logic [7:0]     s2_a, s2_b;
    logic [15:0]    s2_ed;

    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_nxt;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign last_accept = accept && ((sample_count + N_W'(1)) == target);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = (num_samples != '0) ? RUN : DONE;
            RUN:        if (last_accept) state_nxt = DRAIN;
            DRAIN:      if (!s1_v && !s2_v) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    assign s1_exact = 16'(s1_a) * 16'(s1_b);
    assign s1_ed    = (s1_exact >= s1_approx) ? (s1_exact - s1_approx) : (s1_approx - s1_exact);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_approx <= '0;
            s2_v      <= 1'b0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_ed     <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_approx <= in_approx;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_a  <= s1_a;
                s2_b  <= s1_b;
                s2_ed <= s1_ed;
            end
        end
    end

    // One extra carry bit detects overflow; once clamped the sum stays at all-ones.
    assign sum_ext = {1'b0, sum_ed} + (ACC_W+1)'(s2_ed);
    assign sum_nxt = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target       <= '0;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            max_a        <= '0;
            max_b        <= '0;
        end else if (start_ok) begin
            target       <= num_samples;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            max_a        <= '0;
            max_b        <= '0;
        end else begin
            if (accept) sample_count <= sample_count + N_W'(1);
            if (s2_v) begin
                if (s2_ed != '0) err_count <= err_count + N_W'(1);
                sum_ed <= sum_nxt;
                if (s2_ed > max_ed) begin
                    max_ed <= s2_ed;
                    max_a  <= s2_a;
                    max_b  <= s2_b;
                end
            end
        end
    end

endmodule

// File: doc/mul_err_accum.md
Name: mul_err_accum

Overview:
- Streaming error-statistics accumulator that sits directly downstream of the 8x8 approximate multiplier.
- Each transaction carries an operand pair (a, b) and the multiplier's 16-bit approximate product.
- The block pipelines each sample, computes the exact product and the error distance ED = |a*b - approx|, and accumulates error count, ED sum and maximum ED over a programmed number of samples.
- Results feed MED/ER characterisation of the approximate multiplier family.

Parameters:
N_W, 17, width of sample counters (maximum 2^N_W-1 samples per run)
ACC_W, 32, width of the saturating ED-sum accumulator

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous active-high reset
start  input  1  single-cycle run request; latches num_samples
num_samples  input  N_W  number of samples to accept in this run
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample this cycle
in_a  input  8  operand a
in_b  input  8  operand b
in_approx  input  16  approximate product of in_a*in_b from the multiplier
busy  output  1  state is RUN or DRAIN
done  output  1  run complete; level, held until next start or reset
sample_count  output  N_W  samples accepted in current/last run
err_count  output  N_W  samples with approx != exact
sum_ed  output  ACC_W  sum of ED, saturating at 2^ACC_W-1
max_ed  output  16  largest ED seen
max_a  output  8  in_a of first sample reaching max_ed
max_b  output  8  in_b of first sample reaching max_ed

Behaviour:
- Reset (async, any state): FSM=IDLE; in_ready, busy, done, sample_count, err_count, sum_ed, max_ed, max_a, max_b all 0; pipeline valid bits cleared. In-flight samples are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: clear all statistics and sample_count, latch num_samples, done<=0.
  - Go to RUN if num_samples != 0.
  - Otherwise go directly to DONE; done=1 from the next cycle and all statistics stay 0.
- start while in RUN or DRAIN: ignored. Latched target and statistics are unchanged.
- RUN:
  - in_ready = 1 only in RUN (combinational from state).
  - Accept on in_valid & in_ready at an edge; sample_count increments at that edge.
  - On the accept that makes sample_count == target, go to DRAIN at the same edge; in_ready=0 from then on.
  - in_valid=0 cycles are bubbles; no effect.
- Pipeline timing, for a sample accepted at edge k:
  - S1 registers a, b, approx at edge k.
  - S2 registers the exact 16-bit product and ED (16-bit unsigned magnitude) at edge k+1.
  - Statistics update at edge k+2.
- Statistics update rules:
  - err_count += (ED != 0).
  - sum_ed += ED; if the result would exceed 2^ACC_W-1, it clamps there and stays clamped.
  - max_ed/max_a/max_b update only on ED > max_ed (strict), so ties keep the earliest sample.
- DRAIN: transition to DONE at the first edge where both S1 and S2 valid bits are 0. For a last accept at edge k, done rises after edge k+3.
- DONE: outputs hold stable until start or RST.
- ED arithmetic is unsigned 16-bit with no overflow. Exact products range 0..65025; approx is treated as unsigned 16-bit.

Test Plan:
- Exact path: num_samples=4; samples (3,5,15), (255,255,65025), (0,200,0), (16,16,256) -> done 3 cycles after 4th accept; sample_count=4, err_count=0, sum_ed=0, max_ed=0, max_a=max_b=0.
- Error path: num_samples=3; samples (10,10,96), (200,3,610), (7,7,45) -> ED 4, 10, 4; err_count=3, sum_ed=18, max_ed=10, max_a=200, max_b=3.
- Tie and bubbles: num_samples=2 with in_valid gaps of 0, 2 and 5 cycles; EDs 8 then 8 -> max_a/max_b from the first sample; in_ready drops after the 2nd accept; further in_valid pulses are not counted.
- Saturation: ACC_W=17; 3 samples of (255,255,0) -> sum_ed=131071 (not 195075), err_count=3.
- Zero length and ignored start: start with num_samples=0 -> done=1 the next cycle, busy never high. In a separate run, a start pulse during RUN leaves the target and statistics unchanged.
- Reset mid-run: assert RST one cycle after an accept with S1/S2 full -> all outputs 0, IDLE, in_ready=0. A fresh run after reset produces correct statistics.
